// File: rtl/alu_op_sequencer_if.sv
// Bundle of requester, response and ALU pin signals for alu_op_sequencer.
// master: requester/consumer/ALU side. slave: the sequencer itself.
interface alu_op_sequencer_if;
  logic       r0_valid;
  logic       r0_ready;
  logic [2:0] r0_op;
  logic [1:0] r0_fsel;
  logic [7:0] r0_a;
  logic [7:0] r0_b;
  logic       r0_use_acc;

  logic       r1_valid;
  logic       r1_ready;
  logic [2:0] r1_op;
  logic [1:0] r1_fsel;
  logic [7:0] r1_a;
  logic [7:0] r1_b;
  logic       r1_use_acc;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [13:0] resp_result;
  logic        resp_flag;
  logic        resp_ovf;

  logic [7:0] alu_operand;
  logic [7:0] alu_ctrl;
  logic [7:0] alu_res_lo;
  logic [7:0] alu_res_hi;

  logic busy;

  modport master (
    output r0_valid, r0_op, r0_fsel, r0_a, r0_b, r0_use_acc,
    output r1_valid, r1_op, r1_fsel, r1_a, r1_b, r1_use_acc,
    input  r0_ready, r1_ready,
    input  resp_valid, resp_id, resp_result, resp_flag, resp_ovf,
    output resp_ready,
    input  alu_operand, alu_ctrl,
    output alu_res_lo, alu_res_hi,
    input  busy
  );

  modport slave (
    input  r0_valid, r0_op, r0_fsel, r0_a, r0_b, r0_use_acc,
    input  r1_valid, r1_op, r1_fsel, r1_a, r1_b, r1_use_acc,
    output r0_ready, r1_ready,
    output resp_valid, resp_id, resp_result, resp_flag, resp_ovf,
    input  resp_ready,
    output alu_operand, alu_ctrl,
    input  alu_res_lo, alu_res_hi,
    output busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: arbitrates two requesters onto one 8-bit ALU tile and
// sequences load A / load B / execute over the ALU's single operand bus,
// returning the captured result on a valid/ready response port.
// Optional feature macro: ACCUM_EN (accumulator substitutable for operand A).
module alu_op_sequencer #(
  parameter int EXEC_WAIT = 1,
  parameter bit ARB_FIXED = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  alu_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam int CNT_W = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_WAIT - 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [1:0]       fsel_q;
  logic [7:0]       a_q;
  logic [7:0]       b_q;
  logic             id_q;
  logic             last_q;      // 1 = r1 was granted last, so r0 is favoured
  logic [CNT_W-1:0] cnt;
  logic [7:0]       operand_q;
  logic [7:0]       ctrl_q;
  logic             resp_valid_q;
  logic             resp_id_q;
  logic [13:0]      resp_result_q;
  logic             resp_flag_q;
  logic             resp_ovf_q;

  logic       gnt0;
  logic       gnt1;
  logic       accept;
  logic [2:0] sel_op;
  logic [1:0] sel_fsel;
  logic [7:0] sel_a;
  logic [7:0] sel_b;

`ifdef ACCUM_EN
  logic [7:0] acc_q;
  logic       sel_use_acc;
`else
  logic       unused_use_acc;
  assign unused_use_acc = bus.r0_use_acc ^ bus.r1_use_acc;
`endif

  // Grant: only in IDLE; single valid wins outright, contention goes to
  // the pointer (round-robin) or to r0 (fixed priority).
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (bus.r0_valid && bus.r1_valid) begin
        if (ARB_FIXED || last_q) gnt0 = 1'b1;
        else                     gnt1 = 1'b1;
      end else if (bus.r0_valid) begin
        gnt0 = 1'b1;
      end else if (bus.r1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Select the granted requester's fields for latching at accept.
  always_comb begin
    sel_op   = gnt1 ? bus.r1_op   : bus.r0_op;
    sel_fsel = gnt1 ? bus.r1_fsel : bus.r0_fsel;
    sel_b    = gnt1 ? bus.r1_b    : bus.r0_b;
`ifdef ACCUM_EN
    sel_use_acc = gnt1 ? bus.r1_use_acc : bus.r0_use_acc;
    sel_a       = sel_use_acc ? acc_q : (gnt1 ? bus.r1_a : bus.r0_a);
`else
    sel_a       = gnt1 ? bus.r1_a : bus.r0_a;
`endif
  end

  assign accept = gnt0 | gnt1;

  // Sequencer FSM; ALU pin drive is registered so it lines up with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= 3'd0;
      fsel_q        <= 2'd0;
      a_q           <= 8'd0;
      b_q           <= 8'd0;
      id_q          <= 1'b0;
      last_q        <= 1'b1;
      cnt           <= '0;
      operand_q     <= 8'd0;
      ctrl_q        <= 8'h08;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= 14'd0;
      resp_flag_q   <= 1'b0;
      resp_ovf_q    <= 1'b0;
`ifdef ACCUM_EN
      acc_q         <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // operand keeps the last latched A so the ALU A register stays intact
          if (accept) begin
            op_q      <= sel_op;
            fsel_q    <= sel_fsel;
            a_q       <= sel_a;
            b_q       <= sel_b;
            id_q      <= gnt1;
            last_q    <= gnt1;
            operand_q <= sel_a;
            ctrl_q    <= {2'b00, sel_fsel, 1'b1, sel_op};
            state     <= LOAD_A;
          end
        end
        LOAD_A: begin
          operand_q <= b_q;
          ctrl_q    <= {2'b00, fsel_q, 1'b0, op_q};
          state     <= LOAD_B;
        end
        LOAD_B: begin
          // re-present A with en_a=1 so B is not overwritten during EXEC
          operand_q <= a_q;
          ctrl_q    <= {2'b00, fsel_q, 1'b1, op_q};
          cnt       <= '0;
          state     <= EXEC;
        end
        EXEC: begin
          if (cnt == CNT_LAST) begin
            resp_result_q <= {bus.alu_res_hi[5:0], bus.alu_res_lo};
            resp_flag_q   <= bus.alu_res_hi[6];
            resp_ovf_q    <= bus.alu_res_hi[7];
            resp_id_q     <= id_q;
            resp_valid_q  <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready_ok()) begin
            resp_valid_q <= 1'b0;
            ctrl_q       <= 8'h08;
`ifdef ACCUM_EN
            acc_q        <= resp_result_q[7:0];
`endif
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic resp_ready_ok();
    return resp_valid_q && bus.resp_ready;
  endfunction

  assign bus.r0_ready    = gnt0;
  assign bus.r1_ready    = gnt1;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_flag   = resp_flag_q;
  assign bus.resp_ovf    = resp_ovf_q;
  assign bus.alu_operand = operand_q;
  assign bus.alu_ctrl    = ctrl_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU tile and a
// response scoreboard. Honours ACCUM_EN when defined for the build.
module tb_alu_op_sequencer;
  localparam int EW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.EXEC_WAIT(EW), .ARB_FIXED(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        id;
    logic [13:0] res;
    logic        flag;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] tb_acc = 8'd0;
  logic [13:0] last_res;
  logic        last_flag, last_ovf, last_id;

  // Reference ALU: {ovf, flag, res[13:0]}
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [1:0] fsel,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [15:0] full;
    logic        flag;
    case (op)
      3'd0: full = {8'd0, a} + {8'd0, b};
      3'd1: full = {8'd0, a} - {8'd0, b};
      3'd2: full = {8'd0, a & b};
      3'd3: full = {8'd0, a | b};
      3'd4: full = {8'd0, a ^ b};
      3'd5: full = {7'd0, a, 1'b0};
      3'd6: full = {8'd0, ~a};
      default: full = {8'd0, a} * {8'd0, b};
    endcase
    case (fsel)
      2'd0: flag = (a > b);
      2'd1: flag = (a == b);
      2'd2: flag = (a == 8'd0);
      default: flag = ~a[0];
    endcase
    return {|full[15:8], flag, full[13:0]};
  endfunction

  // ALU tile model: A loads when en_a=1, B loads otherwise.
  logic [7:0] alu_a = 8'd0, alu_b = 8'd0;
  logic [15:0] alu_out;
  always @(posedge clk) begin
    if (bus.alu_ctrl[3]) alu_a <= bus.alu_operand;
    else                 alu_b <= bus.alu_operand;
  end
  assign alu_out = alu_fn(bus.alu_ctrl[2:0], bus.alu_ctrl[5:4], alu_a, alu_b);
  assign bus.alu_res_lo = alu_out[7:0];
  assign bus.alu_res_hi = {alu_out[15], alu_out[14], alu_out[13:8]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic id, input logic [2:0] op, input logic [1:0] fsel,
                                  input logic [7:0] a, input logic [7:0] b, input logic use_acc);
    logic [7:0]  aa;
    logic [15:0] r;
    exp_t        e;
`ifdef ACCUM_EN
    aa = use_acc ? tb_acc : a;
`else
    aa = a;
    if (use_acc) aa = a;
`endif
    r = alu_fn(op, fsel, aa, b);
    e.id = id; e.res = r[13:0]; e.flag = r[14]; e.ovf = r[15];
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.r0_valid && bus.r0_ready)
        q.push_back(mk_exp(1'b0, bus.r0_op, bus.r0_fsel, bus.r0_a, bus.r0_b, bus.r0_use_acc));
      if (bus.r1_valid && bus.r1_ready)
        q.push_back(mk_exp(1'b1, bus.r1_op, bus.r1_fsel, bus.r1_a, bus.r1_b, bus.r1_use_acc));
      if (bus.resp_valid && bus.resp_ready) begin
        check("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("sb_result", 32'(bus.resp_result), 32'(e.res));
          check("sb_flag",   32'(bus.resp_flag),   32'(e.flag));
          check("sb_ovf",    32'(bus.resp_ovf),    32'(e.ovf));
          check("sb_id",     32'(bus.resp_id),     32'(e.id));
        end
        last_res = bus.resp_result; last_flag = bus.resp_flag;
        last_ovf = bus.resp_ovf;    last_id = bus.resp_id;
`ifdef ACCUM_EN
        tb_acc = bus.resp_result[7:0];
`endif
      end
    end
  end

  task automatic set_req(input logic id, input logic v, input logic [2:0] op, input logic [1:0] fsel,
                         input logic [7:0] a, input logic [7:0] b, input logic use_acc);
    if (id) begin
      bus.r1_valid = v; bus.r1_op = op; bus.r1_fsel = fsel;
      bus.r1_a = a; bus.r1_b = b; bus.r1_use_acc = use_acc;
    end else begin
      bus.r0_valid = v; bus.r0_op = op; bus.r0_fsel = fsel;
      bus.r0_a = a; bus.r0_b = b; bus.r0_use_acc = use_acc;
    end
  endtask

  task automatic send(input logic id, input logic [2:0] op, input logic [1:0] fsel,
                      input logic [7:0] a, input logic [7:0] b, input logic use_acc);
    int k;
    @(posedge clk); #1;
    set_req(id, 1'b1, op, fsel, a, b, use_acc);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!(id ? bus.r1_ready : bus.r0_ready) && k < 50);
    check("accept_in_time", 32'(k < 50), 32'd1);
    @(posedge clk); #1;
    if (id) bus.r1_valid = 1'b0; else bus.r0_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((q.size() != 0 || bus.busy) && k < 100) begin
      @(negedge clk); k++;
    end
    check("done_in_time", 32'(k < 100), 32'd1);
  endtask

  initial begin
    int   lat;
    int   n;
    int   k;
    logic gseq [4];
    logic acc0, acc1;

    set_req(1'b0, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 1'b0);
    set_req(1'b1, 1'b0, 3'd0, 2'd0, 8'd0, 8'd0, 1'b0);
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid),  32'd0);
    check("rst_resp_id",    32'(bus.resp_id),     32'd0);
    check("rst_result",     32'(bus.resp_result), 32'd0);
    check("rst_alu_ctrl",   32'(bus.alu_ctrl),    32'h08);
    check("rst_operand",    32'(bus.alu_operand), 32'd0);
    check("rst_busy",       32'(bus.busy),        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // r0 add 05+03: latency and response values
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'd0, 2'd0, 8'h05, 8'h03, 1'b0);
    @(negedge clk);
    check("add_ready", 32'(bus.r0_ready), 32'd1);
    @(posedge clk); #1;
    bus.r0_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk); lat++;
    end
    check("add_latency", 32'(lat), 32'(3 + EW));
    check("add_result",  32'(bus.resp_result), 32'h0008);
    check("add_flag",    32'(bus.resp_flag),   32'd1);
    check("add_ovf",     32'(bus.resp_ovf),    32'd0);
    check("add_id",      32'(bus.resp_id),     32'd0);
    wait_done();

    // r0 sub 03-05
    send(1'b0, 3'd1, 2'd0, 8'h03, 8'h05, 1'b0);
    wait_done();
    check("sub_result", 32'(last_res),  32'h3FFE);
    check("sub_ovf",    32'(last_ovf),  32'd1);
    check("sub_flag",   32'(last_flag), 32'd0);

    // r1 mul FF*FF
    send(1'b1, 3'd7, 2'd0, 8'hFF, 8'hFF, 1'b0);
    wait_done();
    check("mul_result", 32'(last_res), 32'h3E01);
    check("mul_ovf",    32'(last_ovf), 32'd1);
    check("mul_id",     32'(last_id),  32'd1);

    // both valid continuously: grants must alternate starting with r0
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'd0, 2'd1, 8'h11, 8'h11, 1'b0);
    set_req(1'b1, 1'b1, 3'd4, 2'd2, 8'h00, 8'h5A, 1'b0);
    n = 0; k = 0;
    while (n < 4 && k < 200) begin
      @(negedge clk); k++;
      acc0 = bus.r0_valid && bus.r0_ready;
      acc1 = bus.r1_valid && bus.r1_ready;
      if (acc0 || acc1) begin
        gseq[n] = acc1;
        n++;
        @(posedge clk); #1;
        if (n == 4) begin
          bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        end else if (acc0) begin
          bus.r0_a = 8'($urandom_range(0, 255)); bus.r0_b = 8'($urandom_range(0, 255));
          bus.r0_op = 3'($urandom_range(0, 7));
        end else begin
          bus.r1_a = 8'($urandom_range(0, 255)); bus.r1_b = 8'($urandom_range(0, 255));
          bus.r1_op = 3'($urandom_range(0, 7));
        end
      end
    end
    check("rr_count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_grant%0d", i), 32'(gseq[i]), 32'(i % 2));
    bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
    wait_done();

    // back-pressure: response held 10 cycles with r1 waiting
    bus.resp_ready = 1'b0;
    send(1'b0, 3'd0, 2'd0, 8'h40, 8'h02, 1'b0);
    k = 0;
    while (!bus.resp_valid && k < 20) begin
      @(negedge clk); k++;
    end
    check("bp_resp_seen", 32'(bus.resp_valid), 32'd1);
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 3'd3, 2'd3, 8'h0F, 8'hF0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result", 32'(bus.resp_result), 32'h0042);
      check("bp_valid",  32'(bus.resp_valid),  32'd1);
      check("bp_busy",   32'(bus.busy),        32'd1);
      check("bp_ready",  32'({bus.r0_ready, bus.r1_ready}), 32'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!bus.r1_ready && k < 20);
    check("bp_resume_accept", 32'(bus.r1_ready), 32'd1);
    @(posedge clk); #1;
    bus.r1_valid = 1'b0;
    wait_done();

    // reset while in LOAD_B
    send(1'b0, 3'd0, 2'd0, 8'h22, 8'h33, 1'b0);
    @(posedge clk); #1;
    check("lb_en_a_low", 32'(bus.alu_ctrl[3]), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("lbrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("lbrst_alu_ctrl",   32'(bus.alu_ctrl),   32'h08);
    check("lbrst_busy",       32'(bus.busy),       32'd0);
    check("lbrst_sb_pending", 32'(q.size()),       32'd1);
    q.delete();
    tb_acc = 8'd0;

    // accumulator chain: 10+20, then use_acc add 01
    send(1'b0, 3'd0, 2'd0, 8'h10, 8'h20, 1'b0);
    wait_done();
    check("acc1_result", 32'(last_res), 32'h0030);
    send(1'b1, 3'd0, 2'd0, 8'h77, 8'h01, 1'b1);
    wait_done();
`ifdef ACCUM_EN
    check("acc2_result", 32'(last_res), 32'h0031);
`else
    check("acc2_result", 32'(last_res), 32'h0078);
`endif

    check("sb_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
